// File: rtl/adc_seq_avg.sv
// adc_seq_avg
// Conversion sequencer and averaging result buffer placed directly after the
// SAR controller. It pulses soc, steps the analog channel select from 0 up to
// nch, and accumulates 1/2/4/8 conversions per channel. Each channel's average,
// tagged with its channel number, goes into a first-word-fall-through FIFO.
//
// Ports
//   clk, rst            core clock, asynchronous active-high reset
//   en                  block enable; low returns to IDLE and keeps FIFO data
//   start               begin a scan (sampled only in IDLE)
//   cont, nch, avg      scan config: continuous mode, last channel,
//                       log2 of samples per channel; captured at start
//   soc / eoc / data    handshake with the SAR controller
//   ch                  analog mux channel select
//   busy                sequencer is not idle
//   rd_en / rd_data     FIFO pop and head word {channel, average}
//   empty, full, level  FIFO status
//   ovf / ovf_clr       sticky overflow flag and its clear
module adc_seq_avg #(
  parameter int SIZE  = 12,
  parameter int CHW   = 3,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       start,
  input  logic                       cont,
  input  logic [CHW-1:0]             nch,
  input  logic [1:0]                 avg,
  output logic                       soc,
  input  logic                       eoc,
  input  logic [SIZE-1:0]            data,
  output logic [CHW-1:0]             ch,
  output logic                       busy,
  input  logic                       rd_en,
  output logic [CHW+SIZE-1:0]        rd_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       ovf,
  input  logic                       ovf_clr
);

  localparam int AW   = $clog2(DEPTH);
  localparam int LW   = $clog2(DEPTH+1);
  localparam int ACCW = SIZE + 3;

  typedef enum logic [1:0] {IDLE, SOC, WAIT, PUSH} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ACCW-1:0]     acc;
  logic [2:0]          cnt;
  logic                cont_q;
  logic [CHW-1:0]      nch_q;
  logic [1:0]          avg_q;
  logic                last_sample;
  logic                last_channel;

  logic [CHW+SIZE-1:0] mem [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [CHW+SIZE-1:0] hold_q;
  logic [CHW+SIZE-1:0] push_entry;
  logic                push;
  logic                pop;
  logic                wr_ok;
  logic                ovf_set;

  // The old sample count compared against 2^avg-1 marks the final sample of
  // a channel; 4-bit math keeps avg=3 (limit 7) free of wrap surprises.
  assign last_sample  = ({1'b0, cnt} == ((4'd1 << avg_q) - 4'd1));
  assign last_channel = (ch == nch_q);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic. Dropping en always lands in IDLE, so a partial average
  // can never reach the FIFO.
  always_comb begin
    state_nxt = state;
    if (!en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nxt = SOC;
        SOC:     state_nxt = WAIT;
        WAIT:    if (eoc) state_nxt = last_sample ? PUSH : SOC;
        PUSH:    state_nxt = (last_channel && !cont_q) ? IDLE : SOC;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs decoded purely from the registered state.
  always_comb begin
    soc  = (state == SOC);
    busy = (state != IDLE);
  end

  // Scan datapath: captured config, channel select, accumulator and sample
  // counter. The config is latched at start so the bus side may change
  // nch/avg/cont mid-scan without disturbing it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch     <= '0;
      acc    <= '0;
      cnt    <= '0;
      cont_q <= 1'b0;
      nch_q  <= '0;
      avg_q  <= '0;
    end else if (!en) begin
      ch  <= '0;
      acc <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ch     <= '0;
            acc    <= '0;
            cnt    <= '0;
            cont_q <= cont;
            nch_q  <= nch;
            avg_q  <= avg;
          end
        end
        WAIT: begin
          if (eoc) begin
            acc <= acc + ACCW'(data);
            cnt <= cnt + 3'd1;
          end
        end
        PUSH: begin
          acc <= '0;
          cnt <= '0;
          if (last_channel) begin
            if (cont_q) ch <= '0;
          end else begin
            ch <= ch + CHW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // FIFO control. A push while full only lands if a pop frees a slot in the
  // same cycle; otherwise it is dropped and flagged as overflow.
  assign push_entry = {ch, SIZE'(acc >> avg_q)};
  assign push       = en && (state == PUSH);
  assign pop        = rd_en && !empty;
  assign wr_ok      = push && (!full || pop);
  assign ovf_set    = push && full && !pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign rd_data = empty ? hold_q : mem[rd_ptr];

  // FIFO storage; no reset needed since entries are only read when valid.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= push_entry;
  end

  // Pointers, occupancy, overflow flag and the held head word. hold_q tracks
  // the head while non-empty so rd_data keeps the last word once drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
      hold_q <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: ;
      endcase
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
      if (!empty) hold_q <= mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_adc_seq_avg.sv
// tb_adc_seq_avg
// Self-checking bench for adc_seq_avg. A SAR responder inside the bench answers
// every soc with an eoc after a random latency, feeding samples from a queue.
// Expected FIFO words come from summing each channel's samples and shifting.
module tb_adc_seq_avg;

  localparam int SIZE  = 12;
  localparam int CHW   = 3;
  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH+1);

  logic                clk = 1'b0;
  logic                rst;
  logic                en;
  logic                start;
  logic                cont;
  logic [CHW-1:0]      nch;
  logic [1:0]          avg;
  logic                soc;
  logic                eoc;
  logic [SIZE-1:0]     data;
  logic [CHW-1:0]      ch;
  logic                busy;
  logic                rd_en;
  logic [CHW+SIZE-1:0] rd_data;
  logic                empty;
  logic                full;
  logic [LW-1:0]       level;
  logic                ovf;
  logic                ovf_clr;

  adc_seq_avg #(.SIZE(SIZE), .CHW(CHW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .cont(cont), .nch(nch),
    .avg(avg), .soc(soc), .eoc(eoc), .data(data), .ch(ch), .busy(busy),
    .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .full(full),
    .level(level), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  // 100 MHz core clock.
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int soc_cnt = 0;
  int eoc_cnt = 0;
  int last_eoc_cyc = 0;
  int sar_cd = 0;
  bit sar_on = 1'b0;
  logic [SIZE-1:0] samp_q [$];
  logic [SIZE-1:0] issued_q [$];
  logic [CHW-1:0]  soc_ch_q [$];

  typedef struct {
    logic [1:0]      avg;
    int              nsamp;
    logic [SIZE-1:0] s [8];
    logic [SIZE-1:0] expv;
  } vec_t;

  vec_t vecs [7];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, expv);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: wait bound expired (busy=%0b eoc_cnt=%0d)", name, busy, eoc_cnt);
  endtask

  // One clock cycle: returns at the falling edge, observes soc, and plays the
  // SAR controller (eoc one or more cycles after the soc cycle).
  task automatic tick();
    @(negedge clk);
    cyc++;
    eoc  = 1'b0;
    data = SIZE'($urandom);
    if (soc === 1'b1) begin
      soc_cnt++;
      soc_ch_q.push_back(ch);
      if (sar_on) sar_cd = 1 + $urandom_range(0, 3);
    end else if (sar_on && sar_cd > 0) begin
      sar_cd--;
      if (sar_cd == 0) begin
        eoc  = 1'b1;
        data = (samp_q.size() > 0) ? samp_q.pop_front() : SIZE'($urandom);
        issued_q.push_back(data);
        eoc_cnt++;
        last_eoc_cyc = cyc;
      end
    end
  endtask

  // Start a scan, then scramble the config inputs to confirm they were latched.
  task automatic applyStimulus(input logic [CHW-1:0] n, input logic [1:0] a, input logic c);
    nch   = n;
    avg   = a;
    cont  = c;
    start = 1'b1;
    tick();
    start = 1'b0;
    nch   = CHW'($urandom);
    avg   = 2'($urandom);
    cont  = 1'($urandom);
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while (busy && n < 3000) begin
      tick();
      n++;
    end
    if (busy) timeoutFail(name);
  endtask

  task automatic waitEoc(input int target);
    int n = 0;
    while (eoc_cnt < target && n < 500) begin
      tick();
      n++;
    end
    if (eoc_cnt < target) timeoutFail("wait_eoc");
  endtask

  task automatic popOne();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  // Scan with random samples against the arithmetic reference: each channel's
  // word is the sum of its 2^avg samples shifted right by avg.
  task automatic runModelScan(input int nv, input int av);
    int                  per = 1 << av;
    logic [CHW+SIZE-1:0] exp_q [$];
    logic [CHW-1:0]      exp_ch [$];
    int                  bad = 0;
    samp_q.delete();
    soc_ch_q.delete();
    soc_cnt = 0;
    for (int c = 0; c <= nv; c++) begin
      int sum = 0;
      for (int k = 0; k < per; k++) begin
        logic [SIZE-1:0] s;
        case ($urandom_range(0, 5))
          0:       s = '0;
          1:       s = '1;
          default: s = SIZE'($urandom);
        endcase
        samp_q.push_back(s);
        sum += int'(s);
        exp_ch.push_back(CHW'(c));
      end
      exp_q.push_back({CHW'(c), SIZE'(sum >> av)});
    end
    applyStimulus(CHW'(nv), 2'(av), 1'b0);
    waitIdle("scan_idle");
    checkOutput("scan_soc_count", soc_cnt, (nv + 1) * per);
    if (soc_ch_q.size() != exp_ch.size()) bad++;
    for (int i = 0; i < soc_ch_q.size() && i < exp_ch.size(); i++)
      if (soc_ch_q[i] !== exp_ch[i]) bad++;
    checkOutput("scan_ch_sequence_errors", bad, 0);
    checkOutput("scan_level", level, nv + 1);
    for (int i = 0; i < exp_q.size(); i++) begin
      checkOutput("scan_rd_data", rd_data, exp_q[i]);
      popOne();
    end
    checkOutput("scan_drained_empty", empty, 1);
    checkOutput("scan_drained_hold", rd_data, exp_q[exp_q.size()-1]);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_soc"}, soc, 0);
    checkOutput({tag, "_ch"}, ch, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_rd_data"}, rd_data, 0);
    checkOutput({tag, "_empty"}, empty, 1);
    checkOutput({tag, "_full"}, full, 0);
    checkOutput({tag, "_level"}, level, 0);
    checkOutput({tag, "_ovf"}, ovf, 0);
  endtask

  initial begin
    int saved;
    vecs[0] = '{avg: 2'd0, nsamp: 1, s: '{12'h5A3, 0, 0, 0, 0, 0, 0, 0}, expv: 12'h5A3};
    vecs[1] = '{avg: 2'd2, nsamp: 4, s: '{12'h100, 12'h101, 12'h102, 12'h105, 0, 0, 0, 0}, expv: 12'h102};
    vecs[2] = '{avg: 2'd2, nsamp: 4, s: '{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 0, 0, 0, 0}, expv: 12'hFFF};
    vecs[3] = '{avg: 2'd1, nsamp: 2, s: '{12'h001, 12'h002, 0, 0, 0, 0, 0, 0}, expv: 12'h001};
    vecs[4] = '{avg: 2'd3, nsamp: 8, s: '{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF}, expv: 12'hFFF};
    vecs[5] = '{avg: 2'd3, nsamp: 8, s: '{0, 1, 2, 3, 4, 5, 6, 7}, expv: 12'h003};
    vecs[6] = '{avg: 2'd1, nsamp: 2, s: '{12'h800, 12'h7FF, 0, 0, 0, 0, 0, 0}, expv: 12'h7FF};

    rst = 1'b1; en = 1'b1; start = 1'b0; cont = 1'b0; nch = '0; avg = '0;
    eoc = 1'b0; data = '0; rd_en = 1'b0; ovf_clr = 1'b0;
    tick();
    tick();
    checkResetValues("reset");
    rst = 1'b0;
    tick();
    sar_on = 1'b1;

    // Single-channel table: soc count, pushed word, busy falls 2 cycles after eoc.
    for (int i = 0; i < 7; i++) begin
      samp_q.delete();
      for (int k = 0; k < vecs[i].nsamp; k++) samp_q.push_back(vecs[i].s[k]);
      soc_cnt = 0;
      applyStimulus('0, vecs[i].avg, 1'b0);
      checkOutput("start_to_soc", soc, 1);
      waitIdle("table_idle");
      checkOutput("busy_fall_delay", cyc - last_eoc_cyc, 2);
      checkOutput("table_soc_count", soc_cnt, vecs[i].nsamp);
      checkOutput("table_level", level, 1);
      checkOutput("table_rd_data", rd_data, {3'd0, vecs[i].expv});
      popOne();
      checkOutput("table_empty_after_pop", empty, 1);
    end

    // Four-channel scan with pairs, then randomized scans.
    runModelScan(3, 1);
    for (int r = 0; r < 8; r++) runModelScan($urandom_range(0, 7), $urandom_range(0, 3));

    // Pop while empty is ignored.
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    checkOutput("pop_empty_level", level, 0);
    checkOutput("pop_empty_flag", empty, 1);

    // Abort mid-WAIT after a partial average; stray eoc afterwards.
    sar_on = 1'b0;
    applyStimulus('0, 2'd1, 1'b0);
    tick();
    eoc = 1'b1;
    data = 12'h010;
    tick();
    tick();
    en = 1'b0;
    tick();
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_ch", ch, 0);
    checkOutput("abort_level", level, 0);
    en = 1'b1;
    saved = soc_cnt;
    eoc = 1'b1;
    data = 12'hFFF;
    tick();
    tick();
    tick();
    checkOutput("stray_eoc_busy", busy, 0);
    checkOutput("stray_eoc_level", level, 0);
    checkOutput("stray_eoc_no_soc", soc_cnt - saved, 0);
    sar_on = 1'b1;
    sar_cd = 0;
    samp_q.delete();
    samp_q.push_back(12'h010);
    samp_q.push_back(12'h030);
    applyStimulus('0, 2'd1, 1'b0);
    waitIdle("after_abort_idle");
    checkOutput("after_abort_rd_data", rd_data, {3'd0, 12'h020});
    popOne();

    // Continuous scan over channels 0..1, avg=1 sample, never read.
    samp_q.delete();
    issued_q.delete();
    eoc_cnt = 0;
    for (int k = 0; k < 40; k++) samp_q.push_back(SIZE'($urandom) | 12'h800);
    applyStimulus(3'd1, 2'd0, 1'b1);
    waitEoc(8);
    tick();
    tick();
    checkOutput("cont_full", full, 1);
    checkOutput("cont_level8", level, 8);
    checkOutput("cont_no_ovf_yet", ovf, 0);
    waitEoc(9);
    tick();
    tick();
    checkOutput("cont_ovf_set", ovf, 1);
    checkOutput("cont_level_after_drop", level, 8);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checkOutput("ovf_clear", ovf, 0);
    waitEoc(10);
    tick();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    checkOutput("push_pop_full_level", level, 8);
    checkOutput("push_pop_full_flag", full, 1);
    checkOutput("push_pop_full_ovf", ovf, 0);
    checkOutput("push_pop_full_head", rd_data, {3'd1, issued_q[1]});
    waitEoc(11);
    tick();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checkOutput("ovf_set_beats_clr", ovf, 1);
    checkOutput("ovf_set_beats_clr_level", level, 8);

    // Asynchronous reset in the middle of the running scan.
    tick();
    checkOutput("pre_reset_busy", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    checkResetValues("async_reset");
    sar_on = 1'b0;
    sar_cd = 0;
    tick();
    rst = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adc_seq_avg.md
# adc_seq_avg

Conversion sequencer and result buffer that sits directly downstream of the SAR controller. It issues `soc` pulses to the SAR controller and steps an analog channel-select through channels 0..`nch`. It accumulates 1/2/4/8 conversions per channel from `data` on each `eoc` and pushes the averaged, channel-tagged result into a first-word-fall-through FIFO for the bus interface to drain.

## Interface
- `SIZE`, 12, result width; matches the SAR controller `data` width.
- `CHW`, 3, channel index width.
- `DEPTH`, 8, FIFO entries; power of 2, ≥2.

- `clk`  in  1  core clock
- `rst`  in  1  asynchronous, active-high reset
- `en`  in  1  block enable; low forces IDLE synchronously and keeps FIFO contents
- `start`  in  1  begin a scan; sampled only in IDLE
- `cont`  in  1  continuous mode: restart at channel 0 after channel `nch`
- `nch`  in  CHW  last channel index of the scan
- `avg`  in  2  log2 of samples per channel (0..3 → 1, 2, 4, 8)
- `soc`  out  1  start-of-conversion pulse to the SAR controller
- `eoc`  in  1  end of conversion from the SAR controller
- `data`  in  SIZE  conversion result, valid while `eoc`=1
- `ch`  out  CHW  analog mux channel select
- `busy`  out  1  state ≠ IDLE
- `rd_en`  in  1  pop FIFO head
- `rd_data`  out  CHW+SIZE  {channel, average} at FIFO head
- `empty`, `full`  out  1  FIFO flags
- `level`  out  clog2(DEPTH+1)  FIFO occupancy
- `ovf`  out  1  sticky overflow flag
- `ovf_clr`  in  1  clears `ovf`

## Operation
- FSM states: IDLE, SOC, WAIT, PUSH. All transitions are gated by `en`. `en`=0 → next state IDLE; acc, cnt, and `ch` are cleared.
- IDLE: if `start` → SOC, with `ch`=0, acc=0, cnt=0. `cont`, `nch`, and `avg` are captured into internal registers at this point and held for the whole scan.
- SOC: `soc`=1 for exactly this one cycle → WAIT.
- WAIT: hold until `eoc`. On `eoc`: acc += `data` (acc width SIZE+3, zero-extended), cnt += 1.
  - If cnt == 2^avg−1 (the old value) → PUSH.
  - Otherwise → SOC.
- PUSH: write {`ch`, acc >> avg} into the FIFO, truncating the shift result to SIZE bits. Then clear acc and cnt.
  - If `ch` == nch: if cont → `ch`=0, go to SOC; otherwise → IDLE.
  - Otherwise → `ch` += 1, go to SOC.
- `eoc` outside WAIT is ignored. `start` outside IDLE is ignored.
- FIFO behaviour:
  - First-word-fall-through: `rd_data` = head whenever `empty`=0, and holds its last value when empty.
  - `rd_en` while empty: ignored, no state change.
  - Push while full with no pop: entry is dropped, `ovf` is set, and the sequence continues.
  - Push and pop in the same cycle while full: both succeed, `level` is unchanged, no overflow.
  - Push and pop in the same cycle while empty: push only.
- `ovf`: if set and `ovf_clr` coincide in a cycle, set wins.
- `nch` > 2^CHW−1 is not possible by width. `ch` never exceeds the captured nch.

## Timing
- Reset values: `soc`=0, `ch`=0, `busy`=0, `rd_data`=0, `empty`=1, `full`=0, `level`=0, `ovf`=0. State is IDLE, acc=0, cnt=0, FIFO pointers 0.
- All outputs are registered or decoded from registered state. There is no combinational path from `eoc` or `data` to outputs.
- `start` sampled at edge t → `soc`=1 during cycle t+1.
- `eoc` at edge e (last sample of a channel) → PUSH during e+1 → entry visible (`empty`=0, `level`+1) after edge e+2.
- `eoc` at edge e (not the last sample) → `soc`=1 during e+1. This matches the SAR controller returning to IDLE one cycle after its DONE state.
- `ch` changes at the PUSH edge. It is stable from the following SOC through the channel's last `eoc`.
- Per-channel overhead: 1 SOC cycle per sample, plus 1 PUSH cycle per channel.
- Reset mid-scan: all state returns to reset values immediately (asynchronous); pending FIFO data is lost.
- `en` dropped mid-WAIT: state is IDLE after the next edge; a late `eoc` is ignored. A partial average is never pushed.

## Test plan
- Single shot, nch=0, avg=0, data=0x5A3 on `eoc`:
  - Exactly one `soc` pulse.
  - FIFO receives {0, 0x5A3}.
  - `busy` falls 2 cycles after `eoc`.
- Averaging, avg=2, data sequence 0x100, 0x101, 0x102, 0x105:
  - 4 `soc` pulses.
  - Pushed value (0x408>>2) = 0x102.
  - Full-scale check: 4×0xFFF gives 0xFFF with no overflow of acc.
- Scan, nch=3, avg=1:
  - `ch` steps 0,1,2,3.
  - 8 `soc` pulses.
  - FIFO holds 4 entries tagged 0..3 in order; `level`=4.
- Continuous, cont=1, nch=1, no reads, DEPTH=8:
  - After 8 pushes `full`=1.
  - 9th push is dropped and `ovf`=1.
  - `rd_en` on the same cycle as a push while full leaves `level`=8 with `ovf` unchanged.
  - `ovf_clr` together with an overflow keeps `ovf`=1.
- Abort and robustness:
  - `en`=0 during WAIT → IDLE next cycle, no push; a stray `eoc` is ignored.
  - `rd_en` while empty leaves `level`=0.
  - `rst` asserted mid-scan → all outputs return to reset values asynchronously.
